// File: rtl/matvec_result_requant.sv
// Requantizes 28-bit matvec results (round, shift, saturate to 14 bits) into a FWFT FIFO with row-end tagging.
// Optional ReLU after saturation: define REQUANT_RELU_EN.
module matvec_result_requant #(
  parameter int IN_WIDTH      = 28,
  parameter int OUT_WIDTH     = 14,
  parameter int SHIFT         = 7,
  parameter int DEPTH         = 8,
  parameter int ROWS          = 8,
  parameter int SAT_CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last,
  input  logic                        clear_stats,
  output logic [SAT_CNT_WIDTH-1:0]    sat_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;

  localparam logic signed [IN_WIDTH:0] RND   = (IN_WIDTH+1)'(RND_INT);
  localparam logic signed [IN_WIDTH:0] MAX_V = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MIN_V = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [AW:0]              FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [RW-1:0]            LAST_ROW = RW'(ROWS-1);
  localparam logic [SAT_CNT_WIDTH-1:0] SAT_MAX  = {SAT_CNT_WIDTH{1'b1}};

  logic signed [IN_WIDTH:0]    ext_s;
  logic signed [IN_WIDTH:0]    shifted_s;
  logic signed [OUT_WIDTH-1:0] sat_val_s;
  logic signed [OUT_WIDTH-1:0] res_s;
  logic                        sat_s;
  logic                        accept_s;
  logic                        pop_s;

  logic [OUT_WIDTH-1:0]     mem_data_q [DEPTH];
  logic                     mem_last_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [RW-1:0]            row_q, row_d;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

  // Round half up, arithmetic shift, clamp; sat flag is taken before any ReLU
  always_comb begin
    ext_s     = $signed({in_data[IN_WIDTH-1], in_data}) + RND;
    shifted_s = ext_s >>> SHIFT;
    if (shifted_s > MAX_V) begin
      sat_val_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat_s     = 1'b1;
    end else if (shifted_s < MIN_V) begin
      sat_val_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat_s     = 1'b1;
    end else begin
      sat_val_s = shifted_s[OUT_WIDTH-1:0];
      sat_s     = 1'b0;
    end
`ifdef REQUANT_RELU_EN
    if (sat_val_s[OUT_WIDTH-1]) begin
      res_s = {OUT_WIDTH{1'b0}};
    end else begin
      res_s = sat_val_s;
    end
`else
    res_s = sat_val_s;
`endif
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != {(AW+1){1'b0}});
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign out_data  = out_valid ? $signed(mem_data_q[rd_ptr_q]) : {OUT_WIDTH{1'b0}};
  assign out_last  = out_valid ? mem_last_q[rd_ptr_q] : 1'b0;
  assign sat_count = sat_cnt_q;

  // Pointer, occupancy, row and statistics next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    row_d     = row_q;
    sat_cnt_d = sat_cnt_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      row_d    = (row_q == LAST_ROW) ? {RW{1'b0}} : row_q + RW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
      row_d    = row_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!accept_s && pop_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
    if (clear_stats) begin
      sat_cnt_d = {SAT_CNT_WIDTH{1'b0}};
    end else if (accept_s && sat_s && (sat_cnt_q != SAT_MAX)) begin
      sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {(AW+1){1'b0}};
      row_q     <= {RW{1'b0}};
      sat_cnt_q <= {SAT_CNT_WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_q     <= row_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // FIFO storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_data_q[wr_ptr_q] <= res_s;
      mem_last_q[wr_ptr_q] <= (row_q == LAST_ROW);
    end
  end

endmodule

// File: tb/tb_matvec_result_requant.sv
// Scoreboard bench for matvec_result_requant: directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_matvec_result_requant;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_last, clear_stats;
  logic signed [27:0] in_data;
  logic signed [13:0] out_data;
  logic [7:0]         sat_count;

  int n_tests = 0;
  int n_fail  = 0;
  int row     = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  typedef struct packed {
    logic signed [13:0] d;
    logic               l;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  matvec_result_requant dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .clear_stats(clear_stats), .sat_count(sat_count)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef REQUANT_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Monitor: compare every popped head against the scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      pop_cnt++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0d expected no output", out_data);
      end else begin
        e = sb.pop_front();
        check("pop_data", out_data, e.d);
        check("pop_last", out_last, e.l);
      end
    end
  end

  task automatic push(input logic signed [27:0] v, input int exp_v, input logic clr);
    int t;
    logic ok;
    t = 0;
    in_valid = 1'b1;
    in_data = v;
    clear_stats = clr;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back({14'(exp_v), (row == 7)});
      row = (row + 1) % 8;
    end
    @(posedge clk);
    #1;
    if (ok) acc_cnt++;
    in_valid = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    row = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 28'sd0; out_ready = 1'b1; clear_stats = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic rounding and one-cycle latency
    check("pre_out_valid", out_valid, 0);
    push(28'sd1000, 8, 1'b0);
    check("lat_valid_pos", out_valid, 1);
    check("lat_data_pos", out_data, 8);
    push(-28'sd1000, relu(-8), 1'b0);
    check("lat_data_neg", out_data, relu(-8));
    check("sat_cnt_zero", sat_count, 0);
    idle(2);
    check("empty_valid", out_valid, 0);
    check("empty_data", out_data, 0);

    // Saturation both directions
    push(28'sd2000000, 8191, 1'b0);
    push(-28'sd2000000, relu(-8192), 1'b0);
    idle(2);
    check("sat_cnt_two", sat_count, 2);

    // Stall: 10 back-to-back with out_ready low
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 10; i++) push(28'(i * 128), i, 1'b0);
      end
      begin
        int t;
        int pc0;
        t = 0;
        while (acc_cnt < 8 && t < 100) begin
          @(negedge clk);
          t++;
        end
        check("stall_accepted", acc_cnt, 8);
        check("stall_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("stall_hold_ready", in_ready, 0);
        check("stall_hold_cnt", acc_cnt, 8);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        pc0 = pop_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("drain_rate", pop_cnt - pc0, 8);
      end
    join
    check("stall_total", acc_cnt, 10);
    idle(4);
    check("stall_sb_empty", sb.size(), 0);

    // Row tagging across a stall
    sync_reset();
    for (int i = 1; i <= 5; i++) push(28'(i * 128), i, 1'b0);
    out_ready = 1'b0;
    for (int i = 6; i <= 8; i++) push(28'(i * 128), i, 1'b0);
    idle(3);
    check("tag_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 9; i <= 16; i++) push(28'(i * 128), i, 1'b0);
    idle(6);
    check("tag_sb_empty", sb.size(), 0);

    // Saturation counter sticks, clear wins over increment
    for (int i = 0; i < 300; i++) push(28'sd2000000, 8191, 1'b0);
    check("sat_cnt_sticky", sat_count, 255);
    push(28'sd2000000, 8191, 1'b1);
    check("sat_cnt_clear", sat_count, 0);
    push(-28'sd2000000, relu(-8192), 1'b0);
    check("sat_cnt_after_clr", sat_count, 1);
    idle(3);

    // Asynchronous reset with 5 entries buffered
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(28'(i * 128), i, 1'b0);
    check("pre_arst_valid", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    sb.delete();
    row = 0;
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push(28'sd128, 1, 1'b0);
    check("post_arst_data", out_data, 1);
    check("post_arst_last", out_last, 0);
    idle(3);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec_result_requant.md
Name: matvec_result_requant

Overview:
- Sits directly downstream of the 8x8 matrix-vector engine. Consumes its 28-bit signed dot-product results over a valid/ready handshake.
- For each result: round, arithmetic right-shift, saturate to 14-bit signed. The 14-bit format matches the engine's input_data format, so results can feed the next 1D-conv layer.
- Buffers results in a small FIFO and tags the last element of each 8-row output vector.
- Keeps a sticky saturating count of clipped results.

Parameters:
- IN_WIDTH, 28, input result width (signed)
- OUT_WIDTH, 14, output sample width (signed)
- SHIFT, 7, right-shift amount applied after rounding; legal range 0..IN_WIDTH-OUT_WIDTH
- DEPTH, 8, FIFO entries; power of two, >=2
- ROWS, 8, results per output vector; drives out_last tagging
- SAT_CNT_WIDTH, 8, width of the saturation counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream result valid; connects to the engine's output_valid
- in_ready  output  1  block can accept; connects to the engine's output_ready
- in_data  input  IN_WIDTH  signed upstream result
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head
- out_data  output  OUT_WIDTH  signed requantized sample at FIFO head
- out_last  output  1  head is row ROWS-1 of its vector
- clear_stats  input  1  synchronous clear of sat_count
- sat_count  output  SAT_CNT_WIDTH  number of saturated results, sticky at max

Behaviour:
- Reset (asynchronous, active-high) sets:
  - read/write pointers and occupancy count to 0
  - row index to 0, sat_count to 0
  - out_valid=0, in_ready=1, out_data=0, out_last=0
  - FIFO storage is not reset.
- Handshakes:
  - Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH). It is a combinational decode of registered count only and never depends on in_valid.
  - out_valid = (count != 0).
  - out_data and out_last come from FIFO head (first-word-fall-through). Both read 0 when empty.
- Arithmetic, evaluated combinationally on in_data and written into the FIFO at the accept edge:
  - Extend to IN_WIDTH+1 bits.
  - Add 2^(SHIFT-1) when SHIFT>0 (round half up).
  - Arithmetic right shift by SHIFT.
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-8192, 8191] at default.
  - sat flag = clamp changed the value.
- Latency: an accepted result is visible at out_data the cycle after acceptance. There is no empty-FIFO bypass.
- Simultaneous accept and pop: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- When full, in_ready=0 even if a pop occurs that cycle (no same-cycle refill).
- Row index:
  - Increments on each accept and wraps ROWS-1 -> 0.
  - The stored last bit is (row index == ROWS-1) at accept time.
- sat_count:
  - Increments on each accept whose sat flag is 1.
  - Holds at 2^SAT_CNT_WIDTH-1.
  - clear_stats forces 0 and takes priority over a same-cycle increment.
- Stall behaviour: out_ready held low with the FIFO full drops in_ready. The upstream engine then holds output_valid and its data stable; no data is lost or duplicated.
- Reset asserted mid-vector discards FIFO contents and restarts row tagging at row 0.

Optional Feature:
- Macro REQUANT_RELU_EN.
- When defined: after saturation, negative results are forced to 0 (ReLU).
  - The sat flag and sat_count are computed before ReLU, so a negative clip still counts.
  - out_data is never negative.
- When undefined: signed saturated values pass unchanged; no ReLU logic is instantiated.

Test Plan:
- Defaults, out_ready=1: push 1000, then -1000 -> out_data 8, then -8, each one cycle after accept; sat_count stays 0.
- Push 2000000, then -2000000 -> out_data 8191, then -8192; sat_count=2. With REQUANT_RELU_EN the second output is 0 and sat_count is still 2.
- out_ready=0, in_valid held high with 10 back-to-back values -> 8 accepted, in_ready=0 from the cycle after the 8th accept. Then raise out_ready -> all 8 drain in order, one per cycle, and the remaining 2 are accepted in order.
- Push 16 results -> out_last=1 exactly on the 8th and 16th outputs; row index wraps correctly across an intervening stall.
- 300 saturating pushes -> sat_count holds at 255. Assert clear_stats in the same cycle as another saturating accept -> sat_count=0.
- Assert reset asynchronously between clock edges with 5 entries buffered -> out_valid=0, in_ready=1 and out_data=0 immediately. The next push of 128 yields out_data 1 with out_last=0.
